// File: rtl/cpu_pkg.sv
// Shared opcode encodings and instruction field positions for the single-cycle
// ALU/control/data-memory slice.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_ADDI = 4'hF;

    // Field a doubles as the upper half of the 4-bit jump immediate.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int FA_MSB  = 3;
    localparam int FA_LSB  = 2;
    localparam int FB_MSB  = 1;
    localparam int FB_LSB  = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/dmem_256x8.sv
// Data memory: synchronous write, asynchronous read, synchronous clear of every
// byte while reset is high.
module dmem_256x8 #(
    parameter int DEPTH = 256,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Reset wins over a pending store so a reset cycle never commits data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_ctrl_dmem.sv
// Single-cycle decode, ALU and next-PC logic wrapped around the data memory;
// the memory array is the only state.
module alu_ctrl_dmem
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] r0,
    input  logic [DATA_W-1:0] sp,
    output logic [1:0]        reg_addr_0,
    output logic [1:0]        reg_addr_1,
    output logic [1:0]        reg_addr_w,
    output logic              reg_w_en,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] sel_w_source,
    output logic [DATA_W-1:0] jump,
    output logic [DATA_W-1:0] alu_result,
    output logic              overflow,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] next_pc,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic [3:0]        opcode;
    logic [1:0]        fieldA;
    logic [1:0]        fieldB;
    logic [3:0]        imm;
    logic [DATA_W-1:0] addSum;
    logic [DATA_W-1:0] subDiff;
    logic [DATA_W-1:0] addiSum;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              regWEn;
    logic              memWEn;
    logic              memREn;
    logic              selMem;
    logic              takeJump;

    assign opcode  = instruction[OPC_MSB:OPC_LSB];
    assign fieldA  = instruction[FA_MSB:FA_LSB];
    assign fieldB  = instruction[FB_MSB:FB_LSB];
    assign imm     = instruction[IMM_MSB:IMM_LSB];
    assign addSum  = in0 + in1;
    assign subDiff = in0 - in1;
    assign addiSum = in0 + DATA_W'(fieldB);
    assign immExt  = {{(DATA_W-4){imm[3]}}, imm};

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        reg_addr_w = fieldA;
        regWEn     = 1'b0;
        memWEn     = 1'b0;
        memREn     = 1'b0;
        selMem     = 1'b0;
        takeJump   = 1'b0;
        offset     = '0;
        memAddr    = in0;
        memWdata   = in1;
        unique case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                alu_result = addSum;
                overflow   = (in0[DATA_W-1] == in1[DATA_W-1]) && (addSum[DATA_W-1] != in0[DATA_W-1]);
                regWEn     = 1'b1;
            end
            OP_SUB: begin
                alu_result = subDiff;
                overflow   = (in0[DATA_W-1] != in1[DATA_W-1]) && (subDiff[DATA_W-1] != in0[DATA_W-1]);
                regWEn     = 1'b1;
            end
            OP_AND: begin
                alu_result = in0 & in1;
                regWEn     = 1'b1;
            end
            OP_OR: begin
                alu_result = in0 | in1;
                regWEn     = 1'b1;
            end
            OP_XOR: begin
                alu_result = in0 ^ in1;
                regWEn     = 1'b1;
            end
            OP_SLT: begin
                alu_result = ($signed(in0) < $signed(in1)) ? DATA_W'(1) : '0;
                regWEn     = 1'b1;
            end
            OP_SLL: begin
                alu_result = in0 << in1[2:0];
                regWEn     = 1'b1;
            end
            OP_SRL: begin
                alu_result = in0 >> in1[2:0];
                regWEn     = 1'b1;
            end
            // jal pushes the return address one slot above the stack pointer.
            OP_JAL: begin
                takeJump = 1'b1;
                offset   = immExt;
                memWEn   = 1'b1;
                memAddr  = sp + DATA_W'(1);
                memWdata = pc + DATA_W'(1);
            end
            OP_LW: begin
                memREn     = 1'b1;
                selMem     = 1'b1;
                reg_addr_w = fieldB;
                regWEn     = 1'b1;
            end
            OP_SW: begin
                memWEn = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_result = subDiff;
                offset     = r0;
                takeJump   = (opcode == OP_BEQ) ? (in0 == in1) : (in0 != in1);
            end
            OP_J: begin
                takeJump = 1'b1;
                offset   = immExt;
            end
            OP_ADDI: begin
                alu_result = addiSum;
                overflow   = !in0[DATA_W-1] && addiSum[DATA_W-1];
                regWEn     = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every side-effecting control; datapath outputs stay live.
    assign reg_addr_0   = fieldA;
    assign reg_addr_1   = fieldB;
    assign reg_w_en     = regWEn & ~rst;
    assign mem_w_en     = memWEn & ~rst;
    assign mem_r_en     = memREn & ~rst;
    assign jump         = {DATA_W{takeJump & ~rst}};
    assign sel_w_source = {DATA_W{selMem & ~rst}};
    assign next_pc      = pc + DATA_W'(1) + (jump & offset);
    assign wb_data      = (alu_result & ~sel_w_source) | (mem_rdata & sel_w_source);

    dmem_256x8 #(
        .DEPTH (MEM_DEPTH),
        .W     (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (en & mem_w_en & ~rst),
        .waddr (memAddr[ADDR_W-1:0]),
        .wdata (memWdata),
        .raddr (in0[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Vector-table bench for alu_ctrl_dmem: each record is driven after a falling
// edge, its expectation queued, and checked before the next rising edge.
module tb_alu_ctrl_dmem;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [7:0] instr;
        logic [7:0] pc;
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] r0;
        logic [7:0] sp;
        logic [7:0] alu;
        logic       ovf;
        logic [1:0] dest;
        logic       rwe;
        logic       mwe;
        logic       mre;
        logic [7:0] sel;
        logic [7:0] jmp;
        logic [7:0] npc;
        logic [7:0] wb;
        logic [7:0] rdata;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] instruction;
    logic [7:0] pc;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] r0;
    logic [7:0] sp;
    logic [1:0] reg_addr_0;
    logic [1:0] reg_addr_1;
    logic [1:0] reg_addr_w;
    logic       reg_w_en;
    logic       mem_w_en;
    logic       mem_r_en;
    logic [7:0] sel_w_source;
    logic [7:0] jump;
    logic [7:0] alu_result;
    logic       overflow;
    logic [7:0] wb_data;
    logic [7:0] next_pc;
    logic [7:0] mem_rdata;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    vec_t expQ[$];

    alu_ctrl_dmem #(.DATA_W(8), .MEM_DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .instruction  (instruction),
        .pc           (pc),
        .in0          (in0),
        .in1          (in1),
        .r0           (r0),
        .sp           (sp),
        .reg_addr_0   (reg_addr_0),
        .reg_addr_1   (reg_addr_1),
        .reg_addr_w   (reg_addr_w),
        .reg_w_en     (reg_w_en),
        .mem_w_en     (mem_w_en),
        .mem_r_en     (mem_r_en),
        .sel_w_source (sel_w_source),
        .jump         (jump),
        .alu_result   (alu_result),
        .overflow     (overflow),
        .wb_data      (wb_data),
        .next_pc      (next_pc),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(
        input string name, input logic rstV, input logic enV,
        input logic [7:0] instr, input logic [7:0] pcV, input logic [7:0] a0,
        input logic [7:0] a1, input logic [7:0] r0V, input logic [7:0] spV,
        input logic [7:0] alu, input logic ovf, input logic [1:0] dest,
        input logic rwe, input logic mwe, input logic mre,
        input logic [7:0] sel, input logic [7:0] jmp, input logic [7:0] npc,
        input logic [7:0] wb, input logic [7:0] rdata);
        vec_t v;
        v.name = name; v.rst = rstV; v.en = enV; v.instr = instr; v.pc = pcV;
        v.in0 = a0; v.in1 = a1; v.r0 = r0V; v.sp = spV; v.alu = alu; v.ovf = ovf;
        v.dest = dest; v.rwe = rwe; v.mwe = mwe; v.mre = mre; v.sel = sel;
        v.jmp = jmp; v.npc = npc; v.wb = wb; v.rdata = rdata;
        return v;
    endfunction

    task automatic checkField(input string vname, input string field,
                              input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%h want=%h", vname, field, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        en          = v.en;
        instruction = v.instr;
        pc          = v.pc;
        in0         = v.in0;
        in1         = v.in1;
        r0          = v.r0;
        sp          = v.sp;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard empty got=0 want=1");
            return;
        end
        e = expQ.pop_front();
        checkField(e.name, "reg_addr_0",   {6'b0, reg_addr_0}, {6'b0, e.instr[3:2]});
        checkField(e.name, "reg_addr_1",   {6'b0, reg_addr_1}, {6'b0, e.instr[1:0]});
        checkField(e.name, "reg_addr_w",   {6'b0, reg_addr_w}, {6'b0, e.dest});
        checkField(e.name, "reg_w_en",     {7'b0, reg_w_en},   {7'b0, e.rwe});
        checkField(e.name, "mem_w_en",     {7'b0, mem_w_en},   {7'b0, e.mwe});
        checkField(e.name, "mem_r_en",     {7'b0, mem_r_en},   {7'b0, e.mre});
        checkField(e.name, "sel_w_source", sel_w_source,       e.sel);
        checkField(e.name, "jump",         jump,               e.jmp);
        checkField(e.name, "alu_result",   alu_result,         e.alu);
        checkField(e.name, "overflow",     {7'b0, overflow},   {7'b0, e.ovf});
        checkField(e.name, "wb_data",      wb_data,            e.wb);
        checkField(e.name, "next_pc",      next_pc,            e.npc);
        checkField(e.name, "mem_rdata",    mem_rdata,          e.rdata);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; instruction = 8'h00; pc = 8'h00;
        in0 = 8'h00; in1 = 8'h00; r0 = 8'h00; sp = 8'h00;

        //                 name          rst   en    instr        pc     in0    in1    r0     sp     alu    ov dst rwe mwe mre sel    jmp    npc    wb     rdata
        // Combinational table; en stays low so memory remains cleared.
        vecs.push_back(mkVec("add_ovf",    1'b0, 1'b0, 8'b0001_0110, 8'h10, 8'h7F, 8'h01, 8'h00, 8'h40, 8'h80, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h80, 8'h00));
        vecs.push_back(mkVec("sub_ovf",    1'b0, 1'b0, 8'b0010_0011, 8'h10, 8'h80, 8'h01, 8'h00, 8'h40, 8'h7F, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h7F, 8'h00));
        vecs.push_back(mkVec("sub_plain",  1'b0, 1'b0, 8'b0010_1001, 8'h10, 8'h05, 8'h03, 8'h00, 8'h40, 8'h02, 0, 2, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h02, 8'h00));
        vecs.push_back(mkVec("and",        1'b0, 1'b0, 8'b0011_1100, 8'h10, 8'hF0, 8'h3C, 8'h00, 8'h40, 8'h30, 0, 3, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h30, 8'h00));
        vecs.push_back(mkVec("or",         1'b0, 1'b0, 8'b0100_0101, 8'h10, 8'hF0, 8'h0F, 8'h00, 8'h40, 8'hFF, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'hFF, 8'h00));
        vecs.push_back(mkVec("xor",        1'b0, 1'b0, 8'b0101_1011, 8'h10, 8'hAA, 8'hFF, 8'h00, 8'h40, 8'h55, 0, 2, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h55, 8'h00));
        vecs.push_back(mkVec("slt_neg",    1'b0, 1'b0, 8'b0110_0001, 8'h10, 8'hFF, 8'h01, 8'h00, 8'h40, 8'h01, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h01, 8'h00));
        vecs.push_back(mkVec("slt_pos",    1'b0, 1'b0, 8'b0110_0100, 8'h10, 8'h01, 8'hFF, 8'h00, 8'h40, 8'h00, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("sll",        1'b0, 1'b0, 8'b0111_1010, 8'h10, 8'h01, 8'h0B, 8'h00, 8'h40, 8'h08, 0, 2, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h08, 8'h00));
        vecs.push_back(mkVec("srl",        1'b0, 1'b0, 8'b1000_1101, 8'h10, 8'h80, 8'h03, 8'h00, 8'h40, 8'h10, 0, 3, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h10, 8'h00));
        vecs.push_back(mkVec("addi_ovf",   1'b0, 1'b0, 8'b1111_0111, 8'h10, 8'h7E, 8'h00, 8'h00, 8'h40, 8'h81, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h81, 8'h00));
        vecs.push_back(mkVec("addi_wrap",  1'b0, 1'b0, 8'b1111_0010, 8'h10, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h01, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h01, 8'h00));
        vecs.push_back(mkVec("nop",        1'b0, 1'b0, 8'b0000_1001, 8'h10, 8'h12, 8'h34, 8'h00, 8'h40, 8'h00, 0, 2, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("beq_taken",  1'b0, 1'b0, 8'b1100_0000, 8'h0A, 8'h05, 8'h05, 8'h03, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h0E, 8'h00, 8'h00));
        vecs.push_back(mkVec("bne_not",    1'b0, 1'b0, 8'b1101_0000, 8'h0A, 8'h05, 8'h05, 8'h03, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00));
        vecs.push_back(mkVec("bne_taken",  1'b0, 1'b0, 8'b1101_0110, 8'h10, 8'h07, 8'h05, 8'hF0, 8'h40, 8'h02, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h00));
        vecs.push_back(mkVec("j_fwd_wrap", 1'b0, 1'b0, 8'b1110_0111, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 8'h06, 8'h00, 8'h00));
        vecs.push_back(mkVec("j_back",     1'b0, 1'b0, 8'b1110_1000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 0, 2, 0, 0, 0, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h00));
        vecs.push_back(mkVec("jal_en0",    1'b0, 1'b0, 8'b1001_1110, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 3, 0, 1, 0, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h00));
        vecs.push_back(mkVec("lw_empty",   1'b0, 1'b0, 8'b1010_0011, 8'h10, 8'h10, 8'h00, 8'h00, 8'h40, 8'h00, 0, 3, 1, 0, 1, 8'hFF, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("sw_en0",     1'b0, 1'b0, 8'b1011_0110, 8'h10, 8'h10, 8'hAB, 8'h00, 8'h40, 8'h00, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("pc_wrap",    1'b0, 1'b0, 8'b0000_0000, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        // Multi-cycle sequences: store then load, jal push, gated and reset-cancelled stores.
        vecs.push_back(mkVec("sw_store",   1'b0, 1'b1, 8'b1011_0110, 8'h10, 8'h10, 8'hAB, 8'h00, 8'h40, 8'h00, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("lw_load",    1'b0, 1'b0, 8'b1010_0011, 8'h10, 8'h10, 8'h00, 8'h00, 8'h40, 8'h00, 0, 3, 1, 0, 1, 8'hFF, 8'h00, 8'h11, 8'hAB, 8'hAB));
        vecs.push_back(mkVec("jal_push",   1'b0, 1'b1, 8'b1001_1110, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 3, 0, 1, 0, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h00));
        vecs.push_back(mkVec("jal_check",  1'b0, 1'b0, 8'b0000_0000, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h21, 8'h00, 8'h21));
        vecs.push_back(mkVec("sw_gated",   1'b0, 1'b0, 8'b1011_0001, 8'h10, 8'h40, 8'h77, 8'h00, 8'h40, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("gated_chk",  1'b0, 1'b0, 8'b0000_0000, 8'h10, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("sw_in_rst",  1'b1, 1'b1, 8'b1011_0001, 8'h10, 8'h40, 8'h77, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("rst_chk40",  1'b0, 1'b0, 8'b0000_0000, 8'h10, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("rst_clr10",  1'b0, 1'b0, 8'b0000_0000, 8'h10, 8'h10, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("jal_in_rst", 1'b1, 1'b1, 8'b1001_1110, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 3, 0, 0, 0, 8'h00, 8'h00, 8'h21, 8'h00, 8'h00));
        vecs.push_back(mkVec("lw_in_rst",  1'b1, 1'b0, 8'b1010_0011, 8'h10, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 0, 3, 0, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00));
        vecs.push_back(mkVec("rst_chk00",  1'b0, 1'b0, 8'b0000_0000, 8'h20, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h21, 8'h00, 8'h00));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
